mux_sel_sequencer: RTL and testbench
====================================

MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 SHALL have parameter PASSES, default 2: number of full 4-step select sweeps per run; legal range 1..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a run; sampled in IDLE only.
REQ-005 SHALL have port hold  input  1  stall; freezes all state and outputs while high.
REQ-006 SHALL have port seed_0  input  8  initial data for lane 0, latched on accepted start.
REQ-007 SHALL have port seed_1  input  8  initial data for lane 1, latched on accepted start.
REQ-008 SHALL have port sel_0  output  2  downstream mux select, lane 0.
REQ-009 SHALL have port sel_1  output  2  downstream mux select, lane 1.
REQ-010 SHALL have port in_0  output  8  downstream mux data, lane 0.
REQ-011 SHALL have port in_1  output  8  downstream mux data, lane 1.
REQ-012 SHALL have port step_valid  output  1  sel/in pair is a valid sweep step this cycle.
REQ-013 SHALL have port busy  output  1  high while in SWEEP.
REQ-014 SHALL have port done  output  1  single-cycle pulse at end of a run.

Function
REQ-015 SHALL implement FSM states IDLE, SWEEP, DONE; all outputs registered.
REQ-016 IDLE + start=1 at an edge SHALL load sel_0=0, sel_1=3, in_0=seed_0, in_1=seed_1, step_valid=1, busy=1, step count=0, and enter SWEEP; first valid step is visible one cycle after start is sampled.
REQ-017 SWEEP with hold=0 SHALL advance one step per cycle: sel_0 increments 0->1->2->3->0, sel_1 decrements 3->2->1->0->3.
REQ-018 At each pass boundary (sel_0 wrapping 3->0) in_0 SHALL increment by 1 and in_1 SHALL decrement by 1, both modulo 256 (FF+1=00, 00-1=FF).
REQ-019 After step 4*PASSES-1 is presented and hold=0, SHALL enter DONE: step_valid=0, busy=0, done=1.
REQ-020 DONE SHALL last exactly one cycle, then enter IDLE with done=0; hold is ignored in DONE.
REQ-021 In IDLE and DONE, sel_0/sel_1/in_0/in_1 SHALL hold their last values.
REQ-022 start SHALL be ignored in SWEEP and DONE; start and done in the same cycle SHALL NOT start a run.
REQ-023 hold=1 in SWEEP SHALL keep step_valid=1 and all outputs stable; the downstream consumer treats a held step as a repeat, not a new step.
REQ-024 Internal step counter SHALL be 8 bits, wide enough for 4*64-1.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, step count=0, sel_0=0, sel_1=0, in_0=00, in_1=00, step_valid=0, busy=0, done=0.
REQ-026 Reset asserted mid-SWEEP SHALL abandon the run with no done pulse; after release, the block waits in IDLE for a new start.

Configuration
REQ-027 Macro MUX_SEL_SEQ_ABORT_EN defined SHALL add input abort (1 bit): abort=1 in SWEEP at an edge SHALL enter IDLE next cycle with step_valid=0, busy=0, no done pulse, outputs holding; abort has priority over hold; abort is ignored in IDLE and DONE.
REQ-028 Macro MUX_SEL_SEQ_ABORT_EN undefined SHALL remove the abort port; a run always completes unless reset.

Verification
REQ-029 PASSES=2, seed_0=FF, seed_1=00, pulse start, hold=0 -> steps (sel_0,sel_1,in_0,in_1)=(0,3,FF,00),(1,2,FF,00),(2,1,FF,00),(3,0,FF,00),(0,3,00,FF)..(3,0,00,FF); done=1 on the cycle after the 8th step.
REQ-030 PASSES=1, seed_0=10, seed_1=20, hold=1 for 3 cycles on step 2 -> (1,2,10,20) held 4 cycles with step_valid=1; total 4 distinct steps; done 7 cycles after the first step.
REQ-031 start held high continuously, PASSES=1 -> runs separated by DONE and one IDLE cycle; start is not accepted in the DONE cycle.
REQ-032 rst_n=0 asynchronously during step 3 -> all outputs 0 immediately, no done; a new start then replays from step 0.
REQ-033 With MUX_SEL_SEQ_ABORT_EN, abort=1 with hold=1 on step 2 -> IDLE next cycle, busy=0, step_valid=0, done never asserted.
REQ-034 PASSES=64 -> exactly 256 steps, in_0 incremented 63 times from seed_0, single done pulse.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// ============================================================================
// Module      : mux_sel_sequencer
// Description : Drives select/data pairs for two downstream 4:1 muxes.
//               Each run performs PASSES sweeps of four select steps.
//               Lane 0 select counts up 0..3 and lane 1 select counts down
//               3..0. At every pass boundary, lane 0 data increments and
//               lane 1 data decrements, both modulo 256. A run ends with a
//               one-cycle done pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : PASSES      sweeps per run (1..64), default 2
// Macro       : MUX_SEL_SEQ_ABORT_EN adds the abort input, which cancels a
//               run in SWEEP without a done pulse.
// Ports       : clk         rising-edge clock
//               rst_n       asynchronous active-low reset
//               start       begin a run (sampled in IDLE only)
//               hold        stall; freezes state and outputs in SWEEP
//               abort       (macro only) cancel the current run
//               seed_0/1    initial lane data, latched on accepted start
//               sel_0/1     lane mux selects
//               in_0/1      lane mux data
//               step_valid  sel/in pair is a valid sweep step
//               busy        high while sweeping
//               done        one-cycle end-of-run pulse
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mux_sel_sequencer #(
   parameter int PASSES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       hold,
`ifdef MUX_SEL_SEQ_ABORT_EN
   input  logic       abort,
`endif
   input  logic [7:0] seed_0,
   input  logic [7:0] seed_1,
   output logic [1:0] sel_0,
   output logic [1:0] sel_1,
   output logic [7:0] in_0,
   output logic [7:0] in_1,
   output logic       step_valid,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Index of the final step of a run
   localparam logic [7:0] LAST_STEP = 8'(4 * PASSES - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] sel_0_q, sel_0_d;
   logic [1:0] sel_1_q, sel_1_d;
   logic [7:0] in_0_q, in_0_d;
   logic [7:0] in_1_q, in_1_d;
   logic       step_valid_q, step_valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       abort_req;

`ifdef MUX_SEL_SEQ_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sel_0_d      = sel_0_q;
      sel_1_d      = sel_1_q;
      in_0_d       = in_0_q;
      in_1_d       = in_1_q;
      step_valid_d = step_valid_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_SWEEP;
               cnt_d        = 8'd0;
               sel_0_d      = 2'd0;
               sel_1_d      = 2'd3;
               in_0_d       = seed_0;
               in_1_d       = seed_1;
               step_valid_d = 1'b1;
               busy_d       = 1'b1;
            end
         end

         S_SWEEP: begin
            // Abort outranks hold so a stalled run can still be cancelled
            if (abort_req) begin
               state_d      = S_IDLE;
               step_valid_d = 1'b0;
               busy_d       = 1'b0;
            end else if (!hold) begin
               if (cnt_q == LAST_STEP) begin
                  // sel/in keep the final step's values through DONE/IDLE
                  state_d      = S_DONE;
                  step_valid_d = 1'b0;
                  busy_d       = 1'b0;
                  done_d       = 1'b1;
               end else begin
                  cnt_d   = cnt_q + 8'd1;
                  sel_0_d = sel_0_q + 2'd1;
                  sel_1_d = sel_1_q - 2'd1;
                  // Pass boundary: lane 0 select wraps 3 -> 0
                  if (sel_0_q == 2'd3) begin
                     in_0_d = in_0_q + 8'd1;
                     in_1_d = in_1_q - 8'd1;
                  end
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d      = S_IDLE;
            step_valid_d = 1'b0;
            busy_d       = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 8'd0;
         sel_0_q      <= 2'd0;
         sel_1_q      <= 2'd0;
         in_0_q       <= 8'h00;
         in_1_q       <= 8'h00;
         step_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sel_0_q      <= sel_0_d;
         sel_1_q      <= sel_1_d;
         in_0_q       <= in_0_d;
         in_1_q       <= in_1_d;
         step_valid_q <= step_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign sel_0      = sel_0_q;
   assign sel_1      = sel_1_q;
   assign in_0       = in_0_q;
   assign in_1       = in_1_q;
   assign step_valid = step_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_sequencer.sv
// ============================================================================
// Module      : tb_mux_sel_sequencer
// Description : Scoreboard bench for mux_sel_sequencer. There are three DUTs,
//               with PASSES = 1, 2 and 64. They share clock, reset, hold and
//               seeds, and each has its own start. Only one DUT runs at a
//               time. Expected steps and done pulses are queued when
//               stimulus is issued. A monitor pops one entry each time any
//               DUT presents a step or done. Each entry also records the
//               expected cycle gap since the previous output.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mux_sel_sequencer;

   localparam int NI = 3;

   typedef struct {
      int         inst;
      bit         is_done;
      logic [1:0] s0;
      logic [1:0] s1;
      logic [7:0] i0;
      logic [7:0] i1;
      int         gap;   // 0 = don't care
   } item_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [NI-1:0] start;
   logic          hold;
   logic          abort;
   logic [7:0]    seed_0, seed_1;
   logic [1:0]    sel0 [NI];
   logic [1:0]    sel1 [NI];
   logic [7:0]    in0  [NI];
   logic [7:0]    in1  [NI];
   logic          sv   [NI];
   logic          bz   [NI];
   logic          dn   [NI];

   item_t exp_q[$];
   int    n_chk  = 0;
   int    n_pass = 0;
   int    cyc = 0;
   int    last_cyc = 0;

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < NI; g++) begin : g_dut
         mux_sel_sequencer #(.PASSES(g == 0 ? 1 : (g == 1 ? 2 : 64))) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[g]),
            .hold       (hold),
`ifdef MUX_SEL_SEQ_ABORT_EN
            .abort      (abort),
`endif
            .seed_0     (seed_0),
            .seed_1     (seed_1),
            .sel_0      (sel0[g]),
            .sel_1      (sel1[g]),
            .in_0       (in0[g]),
            .in_1       (in1[g]),
            .step_valid (sv[g]),
            .busy       (bz[g]),
            .done       (dn[g])
         );
      end
   endgenerate

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h expected=%h", name, got, exp);
   endtask

   task automatic push_item(input int inst, input bit is_done, input logic [1:0] s0,
                            input logic [1:0] s1, input logic [7:0] i0,
                            input logic [7:0] i1, input int gap);
      item_t e;
      e.inst = inst; e.is_done = is_done; e.s0 = s0; e.s1 = s1;
      e.i0 = i0; e.i1 = i1; e.gap = gap;
      exp_q.push_back(e);
   endtask

   // Queue a run: steps 0..upto-1, with step hold_k repeated hold_n extra
   // times, and a done pulse (holding the last step's values) if complete.
   task automatic push_run(input int inst, input int passes, input logic [7:0] s0,
                           input logic [7:0] s1, input int first_gap,
                           input int hold_k, input int hold_n, input int upto);
      logic [1:0] a0, a1;
      logic [7:0] d0, d1;
      for (int k = 0; k < upto; k++) begin
         a0 = 2'(k % 4);
         a1 = 2'(3 - (k % 4));
         d0 = s0 + 8'(k / 4);
         d1 = s1 - 8'(k / 4);
         push_item(inst, 1'b0, a0, a1, d0, d1, (k == 0) ? first_gap : 1);
         if (k == hold_k)
            for (int r = 0; r < hold_n; r++) push_item(inst, 1'b0, a0, a1, d0, d1, 1);
      end
      if (upto == 4 * passes)
         push_item(inst, 1'b1, 2'd3, 2'd0, s0 + 8'(passes - 1), s1 - 8'(passes - 1), 1);
   endtask

   task automatic start_pulse(input int inst);
      @(negedge clk) start[inst] = 1'b1;
      @(negedge clk) start[inst] = 1'b0;
   endtask

   task automatic wait_done(input int inst, input int budget);
      int n = 0;
      while (!dn[inst] && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!dn[inst]) chk("done_timeout", 32'(dn[inst]), 32'd1);
   endtask

   task automatic chk_zero(input int i);
      chk("rst_sel_0", 32'(sel0[i]), 32'd0);
      chk("rst_sel_1", 32'(sel1[i]), 32'd0);
      chk("rst_in_0",  32'(in0[i]),  32'd0);
      chk("rst_in_1",  32'(in1[i]),  32'd0);
      chk("rst_valid", 32'(sv[i]),   32'd0);
      chk("rst_busy",  32'(bz[i]),   32'd0);
      chk("rst_done",  32'(dn[i]),   32'd0);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      item_t       e;
      logic [22:0] got_v, exp_v;
      if (rst_n) begin
         cyc++;
         for (int i = 0; i < NI; i++) begin
            if (sv[i] || dn[i]) begin
               n_chk++;
               got_v = {dn[i], sv[i], bz[i], sel0[i], sel1[i], in0[i], in1[i]};
               if (exp_q.size() == 0) begin
                  $display("FAIL unexpected_output inst=%0d got=%h", i, got_v);
               end else begin
                  e = exp_q.pop_front();
                  exp_v = {(e.is_done ? 3'b100 : 3'b011), e.s0, e.s1, e.i0, e.i1};
                  if (got_v === exp_v && e.inst == i) n_pass++;
                  else $display("FAIL step inst=%0d/%0d got=%h expected=%h",
                                i, e.inst, got_v, exp_v);
                  if (e.gap != 0) begin
                     n_chk++;
                     if (cyc - last_cyc == e.gap) n_pass++;
                     else $display("FAIL gap inst=%0d got=%0d expected=%0d",
                                   i, cyc - last_cyc, e.gap);
                  end
               end
               last_cyc = cyc;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      start = '0; hold = 1'b0; abort = 1'b0; seed_0 = 8'h00; seed_1 = 8'h00;
      #1 rst_n = 1'b0;
      #11;
      for (int i = 0; i < NI; i++) chk_zero(i);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // PASSES=2, seeds FF/00: hand-computed sweep including 8-bit wrap
      seed_0 = 8'hFF; seed_1 = 8'h00;
      push_item(1, 0, 2'd0, 2'd3, 8'hFF, 8'h00, 0);
      push_item(1, 0, 2'd1, 2'd2, 8'hFF, 8'h00, 1);
      push_item(1, 0, 2'd2, 2'd1, 8'hFF, 8'h00, 1);
      push_item(1, 0, 2'd3, 2'd0, 8'hFF, 8'h00, 1);
      push_item(1, 0, 2'd0, 2'd3, 8'h00, 8'hFF, 1);
      push_item(1, 0, 2'd1, 2'd2, 8'h00, 8'hFF, 1);
      push_item(1, 0, 2'd2, 2'd1, 8'h00, 8'hFF, 1);
      push_item(1, 0, 2'd3, 2'd0, 8'h00, 8'hFF, 1);
      push_item(1, 1, 2'd3, 2'd0, 8'h00, 8'hFF, 1);
      start_pulse(1);
      wait_done(1, 40);
      repeat (2) @(negedge clk);

      // PASSES=1, hold for 3 cycles on step (1,2): seen 4 times
      seed_0 = 8'h10; seed_1 = 8'h20;
      push_run(0, 1, 8'h10, 8'h20, 0, 1, 3, 4);
      start_pulse(0);
      @(negedge clk) hold = 1'b1;
      repeat (3) @(negedge clk);
      hold = 1'b0;
      wait_done(0, 40);
      repeat (2) @(negedge clk);

      // hold asserted during DONE must not extend it
      seed_0 = 8'h7F; seed_1 = 8'h80;
      push_run(0, 1, 8'h7F, 8'h80, 0, -1, 0, 4);
      start_pulse(0);
      wait_done(0, 40);
      hold = 1'b1;
      @(negedge clk) hold = 1'b0;
      chk("done_hold_busy", 32'(bz[0]), 32'd0);
      repeat (3) @(negedge clk);

      // start held high: DONE then one IDLE cycle before the next run
      seed_0 = 8'h01; seed_1 = 8'h02;
      push_run(0, 1, 8'h01, 8'h02, 0, -1, 0, 4);
      push_run(0, 1, 8'h01, 8'h02, 2, -1, 0, 4);
      @(negedge clk) start[0] = 1'b1;
      wait_done(0, 40);
      @(negedge clk);
      chk("idle_gap_valid", 32'(sv[0]), 32'd0);
      @(negedge clk) start[0] = 1'b0;
      wait_done(0, 40);
      repeat (3) @(negedge clk);

      // async reset during step 3, then replay from step 0
      seed_0 = 8'h33; seed_1 = 8'h44;
      push_run(1, 2, 8'h33, 8'h44, 0, -1, 0, 3);
      start_pulse(1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero(1);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", 32'(bz[1]), 32'd0);
      push_run(1, 2, 8'h33, 8'h44, 0, -1, 0, 8);
      start_pulse(1);
      wait_done(1, 40);
      repeat (2) @(negedge clk);

      // PASSES=64: 256 steps, in_0 advanced 63 times
      seed_0 = 8'hF0; seed_1 = 8'h05;
      push_run(2, 64, 8'hF0, 8'h05, 0, -1, 0, 256);
      start_pulse(2);
      wait_done(2, 300);
      chk("p64_in_0", 32'(in0[2]), 32'h2F);
      chk("p64_in_1", 32'(in1[2]), 32'hC6);
      repeat (3) @(negedge clk);

`ifdef MUX_SEL_SEQ_ABORT_EN
      // abort together with hold on step 2: idle next cycle, no done
      seed_0 = 8'h00; seed_1 = 8'h00;
      push_run(1, 2, 8'h00, 8'h00, 0, -1, 0, 2);
      start_pulse(1);
      @(negedge clk) begin abort = 1'b1; hold = 1'b1; end
      @(negedge clk) begin abort = 1'b0; hold = 1'b0; end
      chk("abort_valid", 32'(sv[1]), 32'd0);
      chk("abort_busy",  32'(bz[1]), 32'd0);
      repeat (12) @(negedge clk);
`endif

      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
